// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a FIFO: frames are start bit, DBIT data bits (LSB first), SB_TICK-tick stop.
// Latency: the pop and the start bit begin on the same edge; frame length is set by dvsr (tick = dvsr+1 clocks).
// Backpressure: pops only in IDLE when fifo_empty=0; one pop per frame, so the FIFO is drained at line rate.
module uart_tx_fifo_drain #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              fifo_empty,
    input  logic [DBIT-1:0]   fifo_rd_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              tx_busy
);

    // s must reach both 15 (start/data bits) and SB_TICK-1 (stop period)
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [DVSR_W-1:0] cnt;
    logic              tick;
    logic [S_W-1:0]    s, s_next;
    logic [N_W-1:0]    n, n_next;
    logic [DBIT-1:0]   shreg, shreg_next;
    logic              tx_reg, tx_next;

    // >= rather than == so a divisor lowered below the current count ticks at once instead of wrapping
    assign tick = (cnt >= dvsr);

    // Free-running oversample tick counter, period dvsr+1 clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame state, counters, shift register and registered line level
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            shreg  <= '0;
            tx_reg <= 1'b1;
        end else begin
            state  <= state_next;
            s      <= s_next;
            n      <= n_next;
            shreg  <= shreg_next;
            tx_reg <= tx_next;
        end
    end

    // Next-state logic; tx_next is the line level for the state being entered, so tx never glitches
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        shreg_next = shreg;
        tx_next    = tx_reg;
        fifo_rd    = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                // Pop and capture on the same edge: the read data is valid whenever the FIFO is non-empty
                if (!fifo_empty && !reset) begin
                    fifo_rd    = 1'b1;
                    shreg_next = fifo_rd_data;
                    s_next     = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (tick) begin
                    if (s == S_BIT_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                        tx_next    = shreg[0];
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_next = shreg[0];
                if (tick) begin
                    if (s == S_BIT_LAST) begin
                        s_next     = '0;
                        shreg_next = shreg >> 1;
                        if (n == N_LAST) begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end else begin
                            n_next  = n + 1'b1;
                            tx_next = shreg_next[0];
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (tick) begin
                    if (s == S_STOP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench: a queue-based FIFO model feeds the transmitter; captured frames are
// compared sample-by-sample against the ideal frame built from the queued byte and the divisor.
// A second instance with a 2-stop-bit stop period covers the SB_TICK=32 case.
module tb_uart_tx_fifo_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] dvsr = 11'd4;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd, tx, tx_busy;

    logic        fifo_empty32 = 1'b1;
    logic [7:0]  fifo_rd_data32 = 8'h81;
    logic        fifo_rd32, tx32, tx_busy32;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    bit         pend = 1'b0;
    int         pops = 0;
    int         bad_rd = 0;
    logic       samp[0:4095];

    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR_W(11)) dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy)
    );

    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .DVSR_W(11)) dut32 (
        .clk(clk), .reset(reset), .dvsr(dvsr), .fifo_empty(fifo_empty32),
        .fifo_rd_data(fifo_rd_data32), .fifo_rd(fifo_rd32), .tx(tx32), .tx_busy(tx_busy32)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // FIFO model: a pop seen in one cycle retires the head before the next cycle's data is shown
    always @(negedge clk) begin
        if (pend && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
        end
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() > 0) ? q[0] : 8'h00;
        #1;
        pend = fifo_rd;
        if (fifo_rd && (fifo_empty || tx_busy)) bad_rd++;
    end

    function automatic logic cur_busy(input bit w);
        return w ? tx_busy32 : tx_busy;
    endfunction

    function automatic logic cur_tx(input bit w);
        return w ? tx32 : tx;
    endfunction

    // Ideal frame: start region low, then 8 bits of 16*(dv+1) clocks LSB first, then sb*(dv+1) high
    function automatic int frame_errs(input logic [7:0] b, input int dv, input int sb, input int len);
        int bt = 16 * (dv + 1);
        int st = len - 8 * bt - sb * (dv + 1);
        int e = 0;
        logic ex;
        if (st < 1) return 9999;
        for (int i = 0; i < len; i++) begin
            if (i < st) ex = 1'b0;
            else if (i < st + 8 * bt) ex = b[(i - st) / bt];
            else ex = 1'b1;
            if (samp[i] !== ex) e++;
        end
        return e;
    endfunction

    // Record tx once per cycle for as long as tx_busy is high
    task automatic capture(input bit which, input int budget, output int len, output bit to);
        int w = 0;
        len = 0;
        to = 1'b0;
        while (cur_busy(which) !== 1'b1) begin
            if (w >= budget) begin to = 1'b1; return; end
            w++;
            @(negedge clk);
        end
        while (cur_busy(which) === 1'b1) begin
            if (len >= 4096) begin to = 1'b1; return; end
            samp[len] = cur_tx(which);
            len++;
            @(negedge clk);
        end
    endtask

    task automatic idle_gap(output int gap, output int low_err);
        gap = 0;
        low_err = 0;
        while (tx_busy !== 1'b1 && gap < 5000) begin
            if (tx !== 1'b1) low_err++;
            gap++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad = 0, ticks = 0, patt = 0;
        dvsr = 11'd4;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got tx=%b busy=%b rd=%b required 1 0 0", tx, tx_busy, fifo_rd);
        end
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_rd !== 1'b0) bad++;
            if (dut.tick === 1'b1) ticks++;
            if (dut.tick !== ((i % 5) == 4)) patt++;
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL idle_line: got %0d bad cycles required 0", bad); end
        vectors++;
        if (ticks != 40) begin miscompares++; $display("FAIL idle_tick_count: got %0d required 40", ticks); end
        vectors++;
        if (patt != 0) begin miscompares++; $display("FAIL idle_tick_phase: got %0d misplaced ticks required 0", patt); end
    endtask

    task automatic test_single();
        int len, p0, st, e;
        bit to;
        dvsr = 11'd3;
        p0 = pops;
        q.push_back(8'hA5);
        capture(1'b0, 5000, len, to);
        st = len - 512 - 64;
        e = frame_errs(8'hA5, 3, 16, len);
        vectors++;
        if (to) begin miscompares++; $display("FAIL single_timeout: got timeout required frame"); end
        vectors++;
        if (st < 61 || st > 64) begin miscompares++; $display("FAIL single_start_len: got %0d required 61..64", st); end
        vectors++;
        if (e != 0) begin miscompares++; $display("FAIL single_frame: got %0d bad samples required 0", e); end
        repeat (100) @(negedge clk);
        vectors++;
        if (pops - p0 != 1) begin miscompares++; $display("FAIL single_pops: got %0d required 1", pops - p0); end
        vectors++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_after: got busy=%b tx=%b required 0 1", tx_busy, tx);
        end
    endtask

    // Back-to-back frames from a pre-filled queue; every frame and every gap is checked
    task automatic run_batch(input string name, input int dv, input logic [7:0] bytes[$]);
        int len, gap, lerr, p0, st, e, lo, hi;
        bit to;
        dvsr = 11'(dv);
        p0 = pops;
        @(negedge clk);
        foreach (bytes[k]) q.push_back(bytes[k]);
        lo = 15 * (dv + 1) + 1;
        hi = 16 * (dv + 1);
        for (int k = 0; k < bytes.size(); k++) begin
            if (k > 0) begin
                idle_gap(gap, lerr);
                vectors++;
                if (gap != 1 || lerr != 0) begin
                    miscompares++;
                    $display("FAIL %s_gap%0d: got gap=%0d low=%0d required gap=1 low=0", name, k, gap, lerr);
                end
            end
            capture(1'b0, 5000, len, to);
            st = len - 128 * (dv + 1) - 16 * (dv + 1);
            e = frame_errs(bytes[k], dv, 16, len);
            vectors++;
            if (to || e != 0 || st < lo || st > hi) begin
                miscompares++;
                $display("FAIL %s_frame%0d: got to=%0b errs=%0d start=%0d required 0 0 %0d..%0d",
                         name, k, to, e, st, lo, hi);
            end
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (pops - p0 != bytes.size()) begin
            miscompares++;
            $display("FAIL %s_pops: got %0d required %0d", name, pops - p0, bytes.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        b = '{8'h00, 8'hFF, 8'h3C};
        run_batch("b2b", 0, b);
    endtask

    task automatic test_stop32();
        int len, st, e;
        bit to;
        dvsr = 11'd1;
        @(negedge clk);
        fifo_empty32 = 1'b0;
        #1;
        vectors++;
        if (fifo_rd32 !== 1'b1) begin miscompares++; $display("FAIL sb32_pop: got %b required 1", fifo_rd32); end
        @(negedge clk);
        fifo_empty32 = 1'b1;
        #1;
        vectors++;
        if (fifo_rd32 !== 1'b0 || tx_busy32 !== 1'b1) begin
            miscompares++;
            $display("FAIL sb32_started: got rd=%b busy=%b required 0 1", fifo_rd32, tx_busy32);
        end
        capture(1'b1, 5000, len, to);
        st = len - 256 - 64;
        e = frame_errs(8'h81, 1, 32, len);
        vectors++;
        if (to || e != 0 || st < 31 || st > 32) begin
            miscompares++;
            $display("FAIL sb32_frame: got to=%0b errs=%0d start=%0d required 0 0 31..32", to, e, st);
        end
    endtask

    task automatic test_reset_mid();
        int len, w, p0, e;
        bit to;
        dvsr = 11'd0;
        @(negedge clk);
        q.push_back(8'h55);
        w = 0;
        while (tx_busy !== 1'b1 && w < 100) begin w++; @(negedge clk); end
        repeat (16 + 64 + 8) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_bit4: got tx=%b busy=%b required 1 1", tx, tx_busy);
        end
        p0 = pops;
        q.push_back(8'h96);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got tx=%b busy=%b rd=%b required 1 0 0", tx, tx_busy, fifo_rd);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (fifo_rd !== 1'b0 || fifo_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_hold: got rd=%b empty=%b required 0 0", fifo_rd, fifo_empty);
        end
        @(negedge clk);
        reset = 1'b0;
        capture(1'b0, 200, len, to);
        e = frame_errs(8'h96, 0, 16, len);
        vectors++;
        if (to || e != 0 || len != 160) begin
            miscompares++;
            $display("FAIL mid_refresh: got to=%0b errs=%0d len=%0d required 0 0 160", to, e, len);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (pops - p0 != 1) begin miscompares++; $display("FAIL mid_pops: got %0d required 1", pops - p0); end
    endtask

    task automatic test_dvsr_change();
        int patt = 0;
        dvsr = 11'd100;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (50) @(negedge clk);
        vectors++;
        if (dut.tick !== 1'b0) begin miscompares++; $display("FAIL dv_before: got %b required 0", dut.tick); end
        dvsr = 11'd2;
        #1;
        vectors++;
        if (dut.tick !== 1'b1) begin miscompares++; $display("FAIL dv_immediate: got %b required 1", dut.tick); end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (dut.tick !== ((i % 3) == 0)) patt++;
        end
        vectors++;
        if (patt != 0) begin miscompares++; $display("FAIL dv_period: got %0d misplaced ticks required 0", patt); end
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        for (int r = 0; r < 2; r++) begin
            b.delete();
            for (int k = 0; k < 4; k++) b.push_back(8'($urandom));
            run_batch("rand", int'($urandom_range(0, 2)), b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stop32();
        test_reset_mid();
        test_dvsr_change();
        test_random();
        vectors++;
        if (bad_rd != 0) begin
            miscompares++;
            $display("FAIL rd_protocol: got %0d pops while empty or busy required 0", bad_rd);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
